// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared types and constants for the CPU memory controller
package cpu_mem_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   typedef enum logic {GNT_IF, GNT_D} gnt_t;
   localparam int RD_LAT_MAX = 4;
   localparam int SCW = 3;
   localparam int LCW = $clog2(RD_LAT_MAX);
endpackage

// File: rtl/cpu_mem_ctrl_sp_ram.sv
// sp_ram: single-port synchronous RAM, write-first, RD_LAT-deep read pipeline
module sp_ram
   import cpu_mem_pkg::*;
#(
   parameter int DWIDTH = 16,
   parameter int AWIDTH = 12,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              re,
   input  logic [AWIDTH-1:0] addr,
   input  logic [DWIDTH-1:0] wdata,
   output logic [DWIDTH-1:0] rdata,
   output logic              rvalid
);
   logic [DWIDTH-1:0] mem [2**AWIDTH];
   logic [DWIDTH-1:0] q [RD_LAT];
   logic [RD_LAT-1:0] v;
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      q[0] <= we ? wdata : mem[addr];
      for (int i = 1; i < RD_LAT; i++) q[i] <= q[i-1];
   end
   // only the valid tags are reset; the array and data pipeline keep their contents
   always_ff @(posedge clk or posedge rst)
      if (rst) v <= '0;
      else begin
         v[0] <= re;
         for (int i = 1; i < RD_LAT; i++) v[i] <= v[i-1];
      end
   assign rdata  = q[RD_LAT-1];
   assign rvalid = v[RD_LAT-1];
endmodule

// File: rtl/cpu_mem_ctrl.sv
// cpu_mem_ctrl: arbitrates fetch and load/store ports onto one single-port RAM
module cpu_mem_ctrl
   import cpu_mem_pkg::*;
#(
   parameter int DWIDTH     = 16,
   parameter int AWIDTH     = 12,
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [AWIDTH-1:0] if_addr,
   output logic              if_ready,
   output logic              if_valid,
   output logic [DWIDTH-1:0] if_data,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [AWIDTH-1:0] d_addr,
   input  logic [DWIDTH-1:0] d_wdata,
   output logic              d_ready,
   output logic              d_valid,
   output logic [DWIDTH-1:0] d_rdata,
   output logic              busy
);
   state_t            state, state_n;
   gnt_t              gnt, gnt_n;
   logic [SCW-1:0]    starve_cnt, starve_n;
   logic [LCW-1:0]    lat_cnt, lat_n;
   logic [DWIDTH-1:0] if_q, d_q, ram_q;
   logic              ram_rv, can_acc, acc, rd;
   assign can_acc  = state == IDLE || state == RESP;
   assign if_ready = can_acc && if_req && (!d_req || starve_cnt == SCW'(STARVE_MAX));
   assign d_ready  = can_acc && d_req && !if_ready;
   assign acc      = if_ready || d_ready;
   assign rd       = if_ready || (d_ready && !d_we);
   assign if_valid = state == RESP && gnt == GNT_IF;
   assign d_valid  = state == RESP && gnt == GNT_D;
   // outputs show RAM data during the response cycle and the held copy otherwise
   assign if_data  = if_valid ? ram_q : if_q;
   assign d_rdata  = d_valid && ram_rv ? ram_q : d_q;
   assign busy     = state == WAIT || (state == RESP && acc);
   always_comb begin
      state_n  = state;
      gnt_n    = gnt;
      lat_n    = lat_cnt;
      starve_n = (!if_req || if_ready) ? '0 :
                 (d_ready && starve_cnt != SCW'(STARVE_MAX)) ? starve_cnt + 1'b1 : starve_cnt;
      if (acc) begin
         gnt_n   = if_ready ? GNT_IF : GNT_D;
         state_n = (!rd || RD_LAT == 1) ? RESP : WAIT;
         lat_n   = rd ? LCW'(RD_LAT - 1) : '0;
      end else if (state == WAIT) begin
         lat_n   = lat_cnt - 1'b1;
         state_n = lat_cnt == LCW'(1) ? RESP : WAIT;
      end else if (state == RESP) state_n = IDLE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state      <= IDLE;
         gnt        <= GNT_IF;
         starve_cnt <= '0;
         lat_cnt    <= '0;
         if_q       <= '0;
         d_q        <= '0;
      end else begin
         state      <= state_n;
         gnt        <= gnt_n;
         starve_cnt <= starve_n;
         lat_cnt    <= lat_n;
         if_q       <= if_data;
         d_q        <= d_rdata;
      end
   sp_ram #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .RD_LAT(RD_LAT)) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (d_ready && d_we),
      .re    (rd),
      .addr  (if_ready ? if_addr : d_addr),
      .wdata (d_wdata),
      .rdata (ram_q),
      .rvalid(ram_rv)
   );
endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// tb_cpu_mem_ctrl: directed checks on RD_LAT=2, 4 and 1 controller instances
module tb_cpu_mem_ctrl;
   logic        clk = 1'b0, rst = 1'b1;
   logic        if_req[3], if_ready[3], if_valid[3], d_req[3], d_we[3], d_ready[3], d_valid[3], busy[3];
   logic [11:0] if_addr[3], d_addr[3];
   logic [15:0] if_data[3], d_wdata[3], d_rdata[3];
   int          n_chk = 0, n_pass = 0, ng, nv;
   logic [5:0]  gv;
   logic        fgot;
   always #5 clk = ~clk;
   cpu_mem_ctrl #(.RD_LAT(2)) u_l2 (.clk(clk), .rst(rst), .if_req(if_req[0]), .if_addr(if_addr[0]),
      .if_ready(if_ready[0]), .if_valid(if_valid[0]), .if_data(if_data[0]), .d_req(d_req[0]), .d_we(d_we[0]),
      .d_addr(d_addr[0]), .d_wdata(d_wdata[0]), .d_ready(d_ready[0]), .d_valid(d_valid[0]),
      .d_rdata(d_rdata[0]), .busy(busy[0]));
   cpu_mem_ctrl #(.RD_LAT(4)) u_l4 (.clk(clk), .rst(rst), .if_req(if_req[1]), .if_addr(if_addr[1]),
      .if_ready(if_ready[1]), .if_valid(if_valid[1]), .if_data(if_data[1]), .d_req(d_req[1]), .d_we(d_we[1]),
      .d_addr(d_addr[1]), .d_wdata(d_wdata[1]), .d_ready(d_ready[1]), .d_valid(d_valid[1]),
      .d_rdata(d_rdata[1]), .busy(busy[1]));
   cpu_mem_ctrl #(.RD_LAT(1)) u_l1 (.clk(clk), .rst(rst), .if_req(if_req[2]), .if_addr(if_addr[2]),
      .if_ready(if_ready[2]), .if_valid(if_valid[2]), .if_data(if_data[2]), .d_req(d_req[2]), .d_we(d_we[2]),
      .d_addr(d_addr[2]), .d_wdata(d_wdata[2]), .d_ready(d_ready[2]), .d_valid(d_valid[2]),
      .d_rdata(d_rdata[2]), .busy(busy[2]));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic smp;
      @(negedge clk);
   endtask
   task automatic st(input int k, input logic [11:0] a, input logic [15:0] w);
      step;
      d_req[k] = 1'b1; d_we[k] = 1'b1; d_addr[k] = a; d_wdata[k] = w;
      smp;
      chk("store_ready", d_ready[k], 1);
      step;
      d_req[k] = 1'b0; d_we[k] = 1'b0;
   endtask
   initial begin
      for (int k = 0; k < 3; k++) begin
         if_req[k] = 0; if_addr[k] = 0; d_req[k] = 0; d_we[k] = 0; d_addr[k] = 0; d_wdata[k] = 0;
      end
      // reset state
      smp;
      chk("rst_busy", busy[0], 0);
      chk("rst_if_valid", if_valid[0], 0);
      chk("rst_d_valid", d_valid[0], 0);
      chk("rst_if_data", if_data[0], 0);
      chk("rst_d_rdata", d_rdata[0], 0);
      step;
      rst = 1'b0;
      smp;
      chk("post_rst_busy", busy[0], 0);
      // store then load on RD_LAT=2
      step;
      d_req[0] = 1; d_we[0] = 1; d_addr[0] = 12'h010; d_wdata[0] = 16'hBEEF;
      smp;
      chk("first_store_ready", d_ready[0], 1);
      chk("first_store_busy", busy[0], 0);
      step;
      d_we[0] = 0;
      smp;
      chk("store_valid", d_valid[0], 1);
      chk("store_rdata_hold", d_rdata[0], 0);
      chk("load_ready_in_resp", d_ready[0], 1);
      chk("resp_accept_busy", busy[0], 1);
      step;
      d_req[0] = 0;
      smp;
      chk("load_wait_valid", d_valid[0], 0);
      chk("load_wait_busy", busy[0], 1);
      step;
      smp;
      chk("load_valid", d_valid[0], 1);
      chk("load_data", d_rdata[0], 16'hBEEF);
      chk("load_no_if_valid", if_valid[0], 0);
      step;
      smp;
      chk("load_valid_pulse", d_valid[0], 0);
      chk("load_data_hold", d_rdata[0], 16'hBEEF);
      // simultaneous requests
      st(0, 12'h020, 16'h1234);
      st(0, 12'h030, 16'h5678);
      step;
      if_req[0] = 1; if_addr[0] = 12'h020; d_req[0] = 1; d_we[0] = 0; d_addr[0] = 12'h030;
      smp;
      chk("both_d_ready", d_ready[0], 1);
      chk("both_if_ready", if_ready[0], 0);
      step;
      d_req[0] = 0;
      smp;
      chk("wait_if_ready", if_ready[0], 0);
      step;
      smp;
      chk("both_d_valid", d_valid[0], 1);
      chk("both_d_data", d_rdata[0], 16'h5678);
      chk("fetch_ready_in_resp", if_ready[0], 1);
      step;
      if_req[0] = 0;
      smp;
      chk("fetch_wait_valid", if_valid[0], 0);
      step;
      smp;
      chk("fetch_valid", if_valid[0], 1);
      chk("fetch_data", if_data[0], 16'h1234);
      chk("fetch_no_d_valid", d_valid[0], 0);
      // starvation guard
      step;
      d_req[0] = 1; d_we[0] = 0; d_addr[0] = 12'h010; if_req[0] = 1; if_addr[0] = 12'h020;
      ng = 0; gv = '0; fgot = 0;
      for (int c = 0; c < 40 && ng < 6; c++) begin
         smp;
         if (d_ready[0]) begin gv[ng] = 1'b1; ng++; end
         else if (if_ready[0]) begin gv[ng] = 1'b0; ng++; fgot = 1; end
         step;
         if (fgot) if_req[0] = 0;
      end
      d_req[0] = 0; if_req[0] = 0;
      chk("starve_grants", ng, 6);
      chk("starve_order", gv, 6'b101111);
      step; step; step;
      // reset mid-read on RD_LAT=4
      st(1, 12'h040, 16'hCAFE);
      smp;
      chk("l4_store_valid", d_valid[1], 1);
      step;
      d_req[1] = 1;
      smp;
      chk("l4_load_ready", d_ready[1], 1);
      step;
      d_req[1] = 0;
      smp;
      chk("l4_wait_busy", busy[1], 1);
      step;
      rst = 1;
      smp;
      chk("l4_rst_busy", busy[1], 0);
      step;
      rst = 0;
      nv = 0;
      for (int c = 0; c < 8; c++) begin
         smp;
         nv += int'(d_valid[1]);
         step;
      end
      chk("abort_no_valid", nv, 0);
      d_req[1] = 1;
      smp;
      chk("l4_reload_ready", d_ready[1], 1);
      step;
      d_req[1] = 0;
      nv = 0;
      for (int c = 0; c < 3; c++) begin
         smp;
         nv += int'(d_valid[1]);
         step;
      end
      chk("l4_no_early_valid", nv, 0);
      smp;
      chk("l4_valid", d_valid[1], 1);
      chk("l4_data", d_rdata[1], 16'hCAFE);
      // back-to-back stores and fetches on RD_LAT=1
      step;
      for (int i = 0; i < 8; i++) begin
         d_req[2] = 1; d_we[2] = 1; d_addr[2] = 12'(i); d_wdata[2] = 16'hA000 + 16'(i);
         smp;
         chk("bb_store_ready", d_ready[2], 1);
         step;
      end
      d_req[2] = 0; d_we[2] = 0;
      step;
      for (int i = 0; i < 9; i++) begin
         if (i < 8) begin if_req[2] = 1; if_addr[2] = 12'(i); end
         else if_req[2] = 0;
         smp;
         if (i < 8) chk("bb_fetch_ready", if_ready[2], 1);
         if (i > 0) begin
            chk("bb_fetch_valid", if_valid[2], 1);
            chk("bb_fetch_data", if_data[2], 32'hA000 + i - 1);
         end
         step;
      end
      smp;
      chk("bb_valid_end", if_valid[2], 0);
      chk("bb_data_hold", if_data[2], 16'hA007);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
